i2c_ram_arbiter: RTL and testbench
==================================

I2C_RAM_ARBITER -- requirements
Module: i2c_ram_arbiter

Interface
REQ-001 Parameter CLR_DEPTH, default 32: number of RAM locations (0..CLR_DEPTH-1) zeroed by a clear sequence; legal range 1..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 r_req  input  1  I2C-slave-side request; level, held until r_ack.
REQ-005 r_we  input  1  remote request type: 1 = write, 0 = read.
REQ-006 r_addr  input  8  remote RAM address.
REQ-007 r_wdata  input  8  remote write data.
REQ-008 r_ack  output  1  one-cycle completion pulse to remote requester.
REQ-009 r_rdata  output  8  remote read data, valid while r_ack = 1.
REQ-010 m_req, m_we, m_addr[7:0], m_wdata[7:0]  inputs: menu-controller request set, same semantics as r_*.
REQ-011 m_ack  output  1 and m_rdata  output  8: menu completion pulse and read data, same semantics as r_*.
REQ-012 clr_start  input  1  one-cycle pulse requesting a RAM clear sequence.
REQ-013 clr_busy  output  1  high while a clear sequence is executing.
REQ-014 ram_addr  output  8  shared RAM address (registered).
REQ-015 ram_din  output  8  shared RAM write data (registered).
REQ-016 ram_we  output  1  shared RAM write enable (registered).
REQ-017 ram_dout  input  8  shared RAM read data; synchronous RAM, valid one cycle after address.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE, CLEAR.
REQ-019 IDLE priority per edge: pending clear > arbitration between r_req/m_req > stay IDLE.
REQ-020 Arbitration when both requests high: round robin; grant goes to requester not granted last; last-grant register resets to "menu", so remote wins the first tie.
REQ-021 Single request high: granted immediately regardless of last-grant.
REQ-022 On grant (edge k, IDLE→ACCESS): latch winner's we/addr/wdata; during cycle k+1 ram_addr = addr, ram_din = wdata, ram_we = we.
REQ-023 ACCESS→DONE unconditionally; during DONE ram_we = 0 and the winner's ack = 1 for exactly one cycle with rdata = ram_dout (read) or the RAM content at addr (write, read-after-write; value = written data).
REQ-024 DONE→IDLE unconditionally; minimum transaction period 3 cycles; loser's request stays pending and is granted at the next IDLE.
REQ-025 Requester changes to we/addr/wdata after grant are ignored until its ack.
REQ-026 r_rdata/m_rdata hold their last value when not acked; only the granted side's rdata updates.
REQ-027 clr_start seen in any non-CLEAR state sets clr_pending; current transaction completes first; clr_start while clr_busy = 1 is ignored.
REQ-028 IDLE with clr_pending → CLEAR: clear counter = 0, clr_busy = 1 from next cycle.
REQ-029 CLEAR: one write per cycle, ram_addr = counter, ram_din = 0x00, ram_we = 1; counter increments; after address CLR_DEPTH-1 written, next state IDLE, clr_busy = 0, clr_pending = 0; duration exactly CLR_DEPTH cycles.
REQ-030 Requests arriving during CLEAR wait; no ack during CLEAR; arbitration resumes in IDLE with unchanged last-grant.
REQ-031 Counter width 9 bits so CLR_DEPTH = 256 terminates without wrap ambiguity.
REQ-032 r_ack and m_ack never high in the same cycle.

Reset
REQ-033 reset low asynchronously forces: state IDLE, last-grant = menu, clr_pending = 0, counter = 0, all outputs 0 (r_ack, m_ack, r_rdata, m_rdata, clr_busy, ram_addr, ram_din, ram_we).
REQ-034 Reset mid-transaction or mid-clear aborts it; no ack issued; pending requests are re-arbitrated after reset release.

Verification
REQ-035 Remote write r_addr=0x05, r_wdata=0xA5 from IDLE → ram_we=1, ram_addr=0x05, ram_din=0xA5 one cycle after grant; r_ack pulse next cycle; subsequent menu read 0x05 → m_rdata=0xA5 with m_ack.
REQ-036 r_req and m_req raised same edge after reset, both held → r_ack first, m_ack 3 cycles later; repeat tie → menu served first.
REQ-037 clr_start during remote access, CLR_DEPTH=32 → r_ack completes, then clr_busy high 32 cycles, ram_we=1 addresses 0x00..0x1F with din 0x00, then reads of 0x00 and 0x1F return 0x00.
REQ-038 m_req asserted during CLEAR → no m_ack until clr_busy falls; m_ack exactly 3 cycles after IDLE re-entry.
REQ-039 reset asserted during CLEAR at address 0x10 → all outputs 0 immediately; after release, no ack and clr_busy = 0 with no requests.
REQ-040 Remote r_addr changed from 0x05 to 0x06 in ACCESS cycle → ram_addr stays 0x05; r_rdata reflects address 0x05.

Source files
------------

// File: rtl/i2c_ram_arbiter.sv
// Arbitrates a single-port synchronous RAM between the I2C slave (r_*) and the
// menu controller (m_*), and runs a zero-fill clear sequence over the low CLR_DEPTH locations.
module i2c_ram_arbiter #(
  parameter int CLR_DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_req,
  input  logic       r_we,
  input  logic [7:0] r_addr,
  input  logic [7:0] r_wdata,
  output logic       r_ack,
  output logic [7:0] r_rdata,
  input  logic       m_req,
  input  logic       m_we,
  input  logic [7:0] m_addr,
  input  logic [7:0] m_wdata,
  output logic       m_ack,
  output logic [7:0] m_rdata,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;

  localparam logic [8:0] LAST = 9'(CLR_DEPTH - 1);

  state_t     r_state, w_next;
  logic       r_last_m, r_clr_pend, r_gnt_m, r_lat_we, r_ram_we;
  logic [7:0] r_ram_addr, r_ram_din, r_hold_r, r_hold_m;
  logic [8:0] r_cnt;
  logic       w_any, w_pick_m, w_clr_last;
  logic [7:0] w_done_data;

  assign w_any      = r_req | m_req;
  assign w_pick_m   = m_req & (~r_req | ~r_last_m);
  assign w_clr_last = (r_cnt == LAST);
  // ram_din still holds the write data in DONE, so it doubles as the read-after-write value
  assign w_done_data = r_lat_we ? r_ram_din : ram_dout;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_clr_pend) w_next = CLEAR;
               else if (w_any) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      CLEAR:   if (w_clr_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_m   <= 1'b1;
      r_clr_pend <= 1'b0;
      r_gnt_m    <= 1'b0;
      r_lat_we   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_hold_r   <= '0;
      r_hold_m   <= '0;
      r_cnt      <= '0;
    end else begin
      if (clr_start && r_state != CLEAR) r_clr_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_clr_pend) begin
            r_cnt      <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b1;
          end else if (w_any) begin
            r_gnt_m    <= w_pick_m;
            r_lat_we   <= w_pick_m ? m_we : r_we;
            r_ram_we   <= w_pick_m ? m_we : r_we;
            r_ram_addr <= w_pick_m ? m_addr : r_addr;
            r_ram_din  <= w_pick_m ? m_wdata : r_wdata;
            // round-robin history only moves on contested grants
            if (r_req && m_req) r_last_m <= w_pick_m;
          end
        end
        ACCESS: r_ram_we <= 1'b0;
        DONE: begin
          if (r_gnt_m) r_hold_m <= w_done_data;
          else         r_hold_r <= w_done_data;
        end
        CLEAR: begin
          if (w_clr_last) begin
            r_ram_we   <= 1'b0;
            r_clr_pend <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 9'd1;
            r_ram_addr <= r_cnt[7:0] + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r_ack    = (r_state == DONE) & ~r_gnt_m;
  assign m_ack    = (r_state == DONE) &  r_gnt_m;
  assign r_rdata  = r_ack ? w_done_data : r_hold_r;
  assign m_rdata  = m_ack ? w_done_data : r_hold_m;
  assign clr_busy = (r_state == CLEAR);
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_we   = r_ram_we;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Scoreboard bench for i2c_ram_arbiter: stimulus pushes expected ack data/cycle,
// a negedge monitor pops and compares on every ack.
module tb_i2c_ram_arbiter;
  localparam int DEPTH = 32;

  logic       clk = 1'b0, reset = 1'b0;
  logic       r_req = 0, r_we = 0, m_req = 0, m_we = 0, clr_start = 0;
  logic [7:0] r_addr = 0, r_wdata = 0, m_addr = 0, m_wdata = 0;
  logic       r_ack, m_ack, clr_busy, ram_we;
  logic [7:0] r_rdata, m_rdata, ram_addr, ram_din, ram_dout;

  logic [7:0] mem [256];
  int cyc = 0, checks = 0, errors = 0;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t rq[$], mq[$];
  exp_t e_r, e_m;

  i2c_ram_arbiter #(.CLR_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .r_req(r_req), .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata), .r_ack(r_ack), .r_rdata(r_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every ack must match the head of its side's queue in data and cycle
  always @(negedge clk) begin
    if (reset) begin
      if (r_ack && m_ack) chk("dual_ack", {r_ack, m_ack}, 2'b00);
      if (r_ack) begin
        if (rq.size() == 0) chk("r_ack_unexpected", r_ack, 1'b0);
        else begin
          e_r = rq.pop_front();
          chk("r_rdata", r_rdata, e_r.data);
          chk("r_ack_cycle", cyc, e_r.cyc);
        end
      end
      if (m_ack) begin
        if (mq.size() == 0) chk("m_ack_unexpected", m_ack, 1'b0);
        else begin
          e_m = mq.pop_front();
          chk("m_rdata", m_rdata, e_m.data);
          chk("m_ack_cycle", cyc, e_m.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_acks"}, {r_ack, m_ack, clr_busy, ram_we}, 4'b0);
    chk({tag, "_rdata"}, {r_rdata, m_rdata}, 16'h0);
    chk({tag, "_ram"}, {ram_addr, ram_din}, 16'h0);
  endtask

  // issue one request from IDLE; lat = cycles from issue to ack
  task automatic do_req(input logic side, input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, input int lat, input logic chk_ram);
    int c;
    bit got;
    c = cyc;
    got = 0;
    if (side) begin
      mq.push_back('{exp, c + lat});
      m_we = we; m_addr = addr; m_wdata = wd; m_req = 1;
    end else begin
      rq.push_back('{exp, c + lat});
      r_we = we; r_addr = addr; r_wdata = wd; r_req = 1;
    end
    if (chk_ram) begin
      step();
      chk("grant_ram", {ram_we, ram_addr, ram_din}, {we, addr, wd});
    end
    for (int i = 0; i < 200 && !got; i++) begin
      got = side ? m_ack : r_ack;
      if (!got) step();
    end
    if (!got) chk(side ? "m_ack_timeout" : "r_ack_timeout", 0, 1);
    if (side) m_req = 0; else r_req = 0;
    step();
  endtask

  task automatic wait_busy(output int s);
    s = -1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      if (clr_busy) s = cyc; else step();
    end
    if (s < 0) chk("busy_timeout", 0, 1);
  endtask

  initial begin
    int c, s;
    #1 chk_idle_outs("reset");
    step(); step();
    reset = 1;
    step();

    // remote write then menu read-back
    do_req(0, 1, 8'h05, 8'hA5, 8'hA5, 2, 1);
    do_req(1, 0, 8'h05, 8'h00, 8'hA5, 2, 1);

    // address change after grant must not leak into the access
    c = cyc;
    rq.push_back('{8'hA5, c + 2});
    r_we = 0; r_addr = 8'h05; r_req = 1;
    step();
    r_addr = 8'h06;
    chk("lat_addr_access", ram_addr, 8'h05);
    step();
    chk("lat_addr_done", {r_ack, ram_addr}, {1'b1, 8'h05});
    r_req = 0;
    step();
    chk("m_rdata_hold", m_rdata, 8'hA5);

    // ties after reset: remote first, then menu first
    reset = 0;
    #1 chk_idle_outs("reset2");
    step();
    reset = 1;
    step();
    fork
      do_req(0, 0, 8'h10, 8'h00, 8'h2C, 2, 0);
      do_req(1, 0, 8'h11, 8'h00, 8'h2D, 5, 0);
    join
    fork
      do_req(0, 0, 8'h20, 8'h00, 8'h1C, 5, 0);
      do_req(1, 0, 8'h05, 8'h00, 8'hA5, 2, 0);
    join

    // clear requested during a remote access
    c = cyc;
    rq.push_back('{8'h77, c + 2});
    r_we = 1; r_addr = 8'h40; r_wdata = 8'h77; r_req = 1;
    step();
    clr_start = 1;
    step();
    clr_start = 0;
    r_req = 0;
    wait_busy(s);
    chk("clr_start_cycle", s, c + 4);
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_write", {clr_busy, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 8'(i), 8'h00});
      step();
    end
    chk("clr_end", {clr_busy, ram_we}, 2'b00);
    do_req(1, 0, 8'h00, 8'h00, 8'h00, 2, 0);
    do_req(1, 0, 8'h1F, 8'h00, 8'h00, 2, 0);
    do_req(0, 0, 8'h20, 8'h00, 8'h1C, 2, 0);

    // menu request waits out a clear
    clr_start = 1;
    step();
    clr_start = 0;
    wait_busy(s);
    do_req(1, 0, 8'h03, 8'h00, 8'h00, DEPTH + 2, 0);

    // reset in the middle of a clear
    clr_start = 1;
    step();
    clr_start = 0;
    wait_busy(s);
    for (int i = 0; i < 40 && ram_addr != 8'h10; i++) step();
    chk("mid_clr_addr", {clr_busy, ram_addr}, {1'b1, 8'h10});
    reset = 0;
    #1 chk_idle_outs("reset_clr");
    step();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_quiet", {clr_busy, ram_we}, 2'b00);
    end

    chk("rq_drained", rq.size(), 0);
    chk("mq_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
